// File: rtl/ahbl_audio_frame.sv
// AHB-Lite audio framer: channel select, optional DC high-pass, 16-bit truncation,
// per-frame energy and a ping-pong frame buffer read by the CPU over AHB.
module ahbl_audio_frame #(
  parameter int FRAME_LEN = 128,
  parameter int DC_SHIFT  = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HSEL,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  input  logic [31:0] sample_in,
  input  logic        sample_valid,
  input  logic        sample_ws,
  output logic        IRQ
);

  localparam int WW = $clog2(FRAME_LEN);
  localparam int AW = 17 + DC_SHIFT;
  localparam logic [WW-1:0] LAST_IDX = WW'(FRAME_LEN - 1);
  localparam logic [WW-1:0] ONE_IDX  = WW'(1);
  localparam logic [11:0]   WIN_BASE = 12'h200;
  localparam logic [11:0]   WIN_END  = 12'h200 + 12'(2 * FRAME_LEN);

  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    logic signed [15:0] r;
    if (v[16] != v[15]) begin
      r = v[16] ? 16'sh8000 : 16'sh7FFF;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

  // Bus address-phase and control/status registers
  logic [11:0]          addr_q;
  logic                 act_q, wr_q;
  logic [2:0]           ctrl_q;
  logic                 ready_q, ovr_q, rbank_q, irq_q;
  logic [31:0]          energy_q, eacc_q;
  logic [15:0]          fcount_q;
  logic [WW-1:0]        widx_q;
  logic signed [AW-1:0] acc_q;
  logic signed [15:0]   y_q;
  logic signed [16:0]   d_q;
  logic                 yv_q;
  logic [15:0]          mem_q [2*FRAME_LEN];

  logic                 en_s, dc_en_s, wr_s, release_s, ovr_clr_s, accept_s;
  logic signed [15:0]   x_s, y_s;
  logic signed [16:0]   d_s;
  logic signed [AW-1:0] d_ext_s, acc_fwd_s, dc_s;
  logic signed [31:0]   y32_s, sq_s;
  logic [31:0]          term_s, esum_s;
  logic [32:0]          esum_wide_s;
  logic                 complete_s, take_s, drop_s;
  logic [WW-2:0]        widx_rd_s;
  logic [31:0]          rd_word_s;
  logic                 unused_s;

  assign unused_s  = ^{HADDR[31:12], HWDATA[31:3], sample_in[15:0], HTRANS[0]};
  assign HREADYOUT = 1'b1;
  assign IRQ       = irq_q;
  assign HRDATA    = rd_word_s;

  assign en_s      = ctrl_q[0];
  assign dc_en_s   = ctrl_q[2];
  assign wr_s      = act_q & wr_q & HREADY;
  assign release_s = wr_s & (addr_q == 12'h008) & HWDATA[0];
  assign ovr_clr_s = wr_s & (addr_q == 12'h008) & HWDATA[1];

  // Stage 0: d is computed against ACC forwarded from the sample still in stage 2
  assign x_s       = sample_in[31:16];
  assign accept_s  = en_s & sample_valid & (sample_ws == ctrl_q[1]);
  assign d_ext_s   = {{(AW-17){d_q[16]}}, d_q};
  assign acc_fwd_s = (yv_q & dc_en_s) ? acc_q + d_ext_s : acc_q;
  assign dc_s      = acc_fwd_s >>> DC_SHIFT;
  assign d_s       = dc_en_s ? ({x_s[15], x_s} - dc_s[16:0]) : {x_s[15], x_s};
  assign y_s       = dc_en_s ? sat16(d_s) : x_s;

  assign y32_s       = {{16{y_q[15]}}, y_q};
  assign sq_s        = y32_s * y32_s;
  assign term_s      = {8'd0, sq_s[31:8]};
  assign esum_wide_s = {1'b0, eacc_q} + {1'b0, term_s};
  assign esum_s      = esum_wide_s[32] ? 32'hFFFF_FFFF : esum_wide_s[31:0];

  assign complete_s = en_s & yv_q & (widx_q == LAST_IDX);
  assign take_s     = complete_s & (~ready_q | release_s);
  assign drop_s     = complete_s & ~take_s;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q <= 12'd0;
      act_q  <= 1'b0;
      wr_q   <= 1'b0;
    end else if (HREADY) begin
      addr_q <= HADDR[11:0];
      act_q  <= HSEL & HTRANS[1];
      wr_q   <= HWRITE & (HSIZE == 3'b010);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_q   <= 3'd0;
      ready_q  <= 1'b0;
      ovr_q    <= 1'b0;
      rbank_q  <= 1'b0;
      energy_q <= 32'd0;
      fcount_q <= 16'd0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_s && addr_q == 12'h000) ctrl_q <= HWDATA[2:0];
      if (take_s) ready_q <= 1'b1;
      else if (release_s) ready_q <= 1'b0;
      if (drop_s) ovr_q <= 1'b1;
      else if (ovr_clr_s) ovr_q <= 1'b0;
      if (take_s) begin
        rbank_q  <= ~rbank_q;
        energy_q <= esum_s;
        fcount_q <= fcount_q + 16'd1;
      end
      irq_q <= take_s;
    end
  end

  // Sample pipeline: stage 1 holds y, stage 2 stores it and updates the accumulators
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      y_q    <= 16'sd0;
      d_q    <= 17'sd0;
      yv_q   <= 1'b0;
      widx_q <= '0;
      eacc_q <= 32'd0;
      acc_q  <= '0;
    end else begin
      y_q  <= y_s;
      d_q  <= d_s;
      yv_q <= accept_s;
      if (!en_s) begin
        widx_q <= '0;
        eacc_q <= 32'd0;
        acc_q  <= '0;
      end else begin
        if (yv_q) begin
          widx_q <= complete_s ? '0 : widx_q + ONE_IDX;
          eacc_q <= complete_s ? 32'd0 : esum_s;
        end
        if (!dc_en_s) acc_q <= '0;
        else if (yv_q) acc_q <= acc_q + d_ext_s;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (en_s && yv_q) mem_q[{~rbank_q, widx_q}] <= y_q;
  end

  assign widx_rd_s = addr_q[WW:2];

  always_comb begin
    rd_word_s = 32'hBADD_BEEF;
    case (addr_q)
      12'h000: rd_word_s = {29'd0, ctrl_q};
      12'h004: rd_word_s = {29'd0, rbank_q, ovr_q, ready_q};
      12'h008: rd_word_s = 32'd0;
      12'h00C: rd_word_s = energy_q;
      12'h010: rd_word_s = {16'd0, fcount_q};
      default: begin
        if (addr_q >= WIN_BASE && addr_q < WIN_END) begin
          rd_word_s = {mem_q[{rbank_q, widx_rd_s, 1'b1}], mem_q[{rbank_q, widx_rd_s, 1'b0}]};
        end else begin
          rd_word_s = 32'hBADD_BEEF;
        end
      end
    endcase
  end

endmodule

// File: doc/ahbl_audio_frame.md
# ahbl_audio_frame

AHB-Lite slave that consumes the 32-bit PCM samples produced by the I2S microphone interface and assembles them into fixed-length frames for the TinyML feature and inference firmware. It selects one channel, optionally removes DC with a one-pole high-pass, and truncates each sample to 16-bit signed. It accumulates per-frame energy and stores frames in a ping-pong buffer. The CPU reads a completed frame over AHB while the next frame fills, and is notified by IRQ.

## Interface
- FRAME_LEN, 128: samples per frame; power of 2, 8..256.
- DC_SHIFT, 8: high-pass pole, dc = ACC >>> DC_SHIFT.
- HCLK  in  1  bus clock; every register in this block is on HCLK.
- HRESETn  in  1  reset, asynchronous, active-low.
- HADDR  in  32  AHB address.
- HTRANS  in  2  AHB transfer type.
- HWRITE  in  1  AHB write.
- HSIZE  in  3  AHB size; only 32-bit accesses are supported.
- HWDATA  in  32  AHB write data.
- HSEL  in  1  slave select.
- HREADY  in  1  bus ready.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  tied to 1.
- sample_in  in  32  I2S sample word; bits [31:16] are the PCM value.
- sample_valid  in  1  one-HCLK pulse per received sample; back-to-back pulses are legal.
- sample_ws  in  1  channel of sample_in: 0 = left, 1 = right.
- IRQ  out  1  one-cycle pulse on frame completion.

## Operation
- Address phase registered when HREADY=1. Data phase decodes on HADDR_d[11:0].
- CTRL 0x000, RW:
  - bit0 EN.
  - bit1 CH_SEL: accept samples with sample_ws==CH_SEL.
  - bit2 DC_EN.
- STATUS 0x004, RO:
  - bit0 READY.
  - bit1 OVR, sticky.
  - bit2 RBANK, the bank currently visible to the CPU.
- CLEAR 0x008, WO, write-1:
  - bit0 RELEASE: clears READY.
  - bit1 clears OVR.
  - Reads return 0.
- ENERGY 0x00C, RO: energy of the last completed frame.
- FCOUNT 0x010, RO: 16-bit count of completed frames; wraps at 0xFFFF→0.
- Frame window 0x200..0x200+2*FRAME_LEN-1, RO:
  - Word i = {s[2i+1], s[2i]} from bank RBANK.
  - Window is readable regardless of READY.
- Any other offset reads 0xBADDBEEF. Writes to RO or unmapped offsets are ignored.
- Sample path, for each accepted sample (EN=1, sample_valid=1, sample_ws==CH_SEL):
  - x = sample_in[31:16], 16-bit signed.
  - With DC_EN=1:
    - d = x − dc, 17-bit signed.
    - ACC ← ACC + d, where ACC is (17+DC_SHIFT)-bit signed.
    - y = sat16(d), saturated to [−32768, 32767].
  - With DC_EN=0: y = x and ACC is held at 0.
  - Energy term = (y·y) >> 8. It is added to a 32-bit accumulator that saturates at 0xFFFFFFFF.
- Write side:
  - Sample y is stored at index widx of bank WBANK = ~RBANK.
  - widx increments per stored sample.
- Frame completion, when the sample at widx = FRAME_LEN−1 is stored:
  - If READY=0, or RELEASE is written in the same cycle:
    - RBANK toggles.
    - READY←1.
    - ENERGY←final accumulator value.
    - FCOUNT++.
    - IRQ pulses.
  - Otherwise the frame is dropped: OVR←1, with no swap, no IRQ and no FCOUNT change.
  - In both cases widx←0 and the energy accumulator←0.
- EN cleared: widx, energy accumulator and ACC are reset to 0. READY, OVR, RBANK and the banks keep their values. Samples are ignored while EN=0.
- Simultaneous events:
  - RELEASE in the same cycle as completion: the release takes effect first.
  - OVR set and OVR clear in the same cycle: set wins.

## Timing
- Reset value of every register: 0. This includes CTRL, READY, OVR, RBANK=0, ENERGY, FCOUNT, widx, ACC, IRQ, and the address-phase registers.
  - HRDATA during reset decodes offset 0.
  - Bank contents are undefined.
- Pipeline, with the sample_valid edge as cycle 0:
  - Edge 1: y is registered.
  - Edge 2: memory write, energy accumulate, ACC update.
  - The completion effects (READY, ENERGY, RBANK, FCOUNT) and the rising edge of IRQ all occur at edge 2 of the last sample. IRQ falls at the next edge.
- Register reads are combinational on the data phase with zero wait states. A write takes effect at the end of its data phase.
- ACC feedback delay: a sample must see the ACC update of the previous sample. When pulses arrive back-to-back, d is computed against the ACC value forwarded from stage 2.

## Test plan
All directed tests are run with FRAME_LEN=8.
- Reset and decode: after reset, CTRL/STATUS/ENERGY/FCOUNT read 0, offset 0x020 reads 0xBADDBEEF, IRQ=0.
- Basic frame: CTRL=0x1, feed left samples x=k·256 for k=0..7.
  - Window words read 0x01000000, 0x03000200, 0x05000400, 0x07000600.
  - ENERGY=0x8C00, STATUS=0x5, FCOUNT=1.
  - IRQ is high for exactly one cycle.
- Channel filter: interleave right samples (ws=1, value 0x7FFF) with the same left stream. The result is identical to the basic frame.
- Overrun: complete a second frame without RELEASE.
  - STATUS=0x7, FCOUNT=1, window unchanged, no IRQ.
  - Then write CLEAR=0x3 and complete a third frame: STATUS=0x1 (RBANK=0), FCOUNT=2.
- DC removal: CTRL=0x5, DC_SHIFT=8, constant x=1000 back-to-back. The first three stored samples are 1000, 997, 993.
- EN drop mid-frame: feed 3 samples, clear EN, set EN, then feed 8 samples x=k·256. The frame equals the basic-frame result and FCOUNT increments exactly once.
